// File: rtl/adcv_conv_sequencer.sv
// Conversion sequencer for the ADC decode pipeline: paces sample strobes, tracks them
// through the fixed decoder latency, averages 2^k codes and hands results downstream.
module adcv_conv_sequencer #(
    parameter int B            = 8,
    parameter int PIPE_LAT     = 6,
    parameter int AVG_LOG2_MAX = 4,
    parameter int PER_W        = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic [PER_W-1:0] cfg_period,
    input  logic [2:0]       cfg_avg_log2,
    input  logic [15:0]      cfg_count,
    output logic             sample_valid,
    input  logic [B-1:0]     dec_bin,
    output logic [B-1:0]     res_data,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             busy,
    output logic             overrun,
    output logic             done
);

    localparam int ACC_W = B + AVG_LOG2_MAX;
    localparam int ISS_W = 16 + AVG_LOG2_MAX;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                  state_r;
    logic [PER_W-1:0]        period_r;
    logic [PER_W-1:0]        per_cnt_r;
    logic [2:0]              k_r;
    logic                    cont_r;
    logic [ISS_W-1:0]        limit_r;
    logic [ISS_W-1:0]        issued_r;
    logic [PIPE_LAT-1:0]     dl_r;
    logic [ACC_W-1:0]        acc_r;
    logic [AVG_LOG2_MAX-1:0] tap_cnt_r;
    logic                    sample_valid_r;
    logic                    res_valid_r;
    logic [B-1:0]            res_data_r;
    logic                    busy_r;
    logic                    overrun_r;
    logic                    done_r;

    logic [2:0]              k_clip_s;
    logic [PER_W-1:0]        eff_period_s;
    logic [ISS_W-1:0]        lim_start_s;
    logic [ISS_W-1:0]        issued_inc_s;
    logic                    tap_s;
    logic [ACC_W-1:0]        sum_s;
    logic [B-1:0]            avg_s;
    logic [AVG_LOG2_MAX-1:0] grp_last_s;
    logic                    complete_s;
    logic                    dl_empty_next_s;
    logic                    drain_exit_s;
    logic                    start_acc_s;

    // Config decode, accumulation arithmetic and pipeline-empty detection.
    always_comb begin
        k_clip_s        = (cfg_avg_log2 > 3'(AVG_LOG2_MAX)) ? 3'(AVG_LOG2_MAX) : cfg_avg_log2;
        eff_period_s    = (cfg_period == {PER_W{1'b0}}) ? PER_W'(1'b1) : cfg_period;
        lim_start_s     = ISS_W'(cfg_count) << k_clip_s;
        issued_inc_s    = issued_r + ISS_W'(1'b1);
        tap_s           = dl_r[PIPE_LAT-1];
        sum_s           = acc_r + ACC_W'(dec_bin);
        avg_s           = B'(sum_s >> k_r);
        grp_last_s      = ~({AVG_LOG2_MAX{1'b1}} << k_r);
        complete_s      = tap_s && (tap_cnt_r == grp_last_s);
        // The current tap may still be high; it is consumed on the exit edge.
        dl_empty_next_s = !sample_valid_r && (dl_r[PIPE_LAT-2:0] == {(PIPE_LAT-1){1'b0}});
        drain_exit_s    = (state_r == DRAIN) && dl_empty_next_s;
        start_acc_s     = (state_r == IDLE) && start;
    end

    // Run-control FSM: strobe pacing, issue limit, busy and done.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r        <= IDLE;
            period_r       <= {PER_W{1'b0}};
            per_cnt_r      <= {PER_W{1'b0}};
            k_r            <= 3'd0;
            cont_r         <= 1'b0;
            limit_r        <= {ISS_W{1'b0}};
            issued_r       <= {ISS_W{1'b0}};
            sample_valid_r <= 1'b0;
            busy_r         <= 1'b0;
            done_r         <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    sample_valid_r <= 1'b0;
                    if (start) begin
                        period_r       <= eff_period_s;
                        k_r            <= k_clip_s;
                        cont_r         <= (cfg_count == 16'd0);
                        limit_r        <= lim_start_s;
                        issued_r       <= ISS_W'(1'b1);
                        per_cnt_r      <= eff_period_s - PER_W'(1'b1);
                        sample_valid_r <= 1'b1;
                        busy_r         <= 1'b1;
                        if ((cfg_count != 16'd0) && (lim_start_s == ISS_W'(1'b1))) begin
                            state_r <= DRAIN;
                        end else begin
                            state_r <= RUN;
                        end
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                RUN: begin
                    if (stop) begin
                        sample_valid_r <= 1'b0;
                        state_r        <= DRAIN;
                    end else if (per_cnt_r == {PER_W{1'b0}}) begin
                        sample_valid_r <= 1'b1;
                        per_cnt_r      <= period_r - PER_W'(1'b1);
                        // Continuous mode never counts, so the issue counter cannot wrap.
                        if (!cont_r) begin
                            issued_r <= issued_inc_s;
                            if (issued_inc_s == limit_r) begin
                                state_r <= DRAIN;
                            end else begin
                                state_r <= RUN;
                            end
                        end else begin
                            state_r <= RUN;
                        end
                    end else begin
                        sample_valid_r <= 1'b0;
                        per_cnt_r      <= per_cnt_r - PER_W'(1'b1);
                    end
                end
                DRAIN: begin
                    sample_valid_r <= 1'b0;
                    if (dl_empty_next_s) begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end else begin
                        state_r <= DRAIN;
                    end
                end
                default: begin
                    state_r        <= IDLE;
                    sample_valid_r <= 1'b0;
                    busy_r         <= 1'b0;
                end
            endcase
        end
    end

    // Delay line and accumulator; a partial group left at the end of a run is thrown away.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dl_r      <= {PIPE_LAT{1'b0}};
            acc_r     <= {ACC_W{1'b0}};
            tap_cnt_r <= {AVG_LOG2_MAX{1'b0}};
        end else begin
            dl_r <= {dl_r[PIPE_LAT-2:0], sample_valid_r};
            if (drain_exit_s || complete_s) begin
                acc_r     <= {ACC_W{1'b0}};
                tap_cnt_r <= {AVG_LOG2_MAX{1'b0}};
            end else if (tap_s) begin
                acc_r     <= sum_s;
                tap_cnt_r <= tap_cnt_r + AVG_LOG2_MAX'(1'b1);
            end else begin
                acc_r     <= acc_r;
                tap_cnt_r <= tap_cnt_r;
            end
        end
    end

    // Result register with valid/ready handshake and sticky overrun.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            res_data_r  <= {B{1'b0}};
            res_valid_r <= 1'b0;
            overrun_r   <= 1'b0;
        end else begin
            if (complete_s) begin
                if (!res_valid_r || res_ready) begin
                    res_data_r  <= avg_s;
                    res_valid_r <= 1'b1;
                end else begin
                    overrun_r <= 1'b1;
                end
            end else if (res_ready) begin
                res_valid_r <= 1'b0;
            end else begin
                res_valid_r <= res_valid_r;
            end
            if (start_acc_s) begin
                overrun_r <= 1'b0;
            end else begin
                overrun_r <= overrun_r | (complete_s && res_valid_r && !res_ready);
            end
        end
    end

    assign sample_valid = sample_valid_r;
    assign res_data     = res_data_r;
    assign res_valid    = res_valid_r;
    assign busy         = busy_r;
    assign overrun      = overrun_r;
    assign done         = done_r;

endmodule

// File: tb/tb_adcv_conv_sequencer.sv
// Directed bench for adcv_conv_sequencer: a decoder model feeds codes, a scoreboard
// monitor checks every accepted result against hand-computed averages.
`timescale 1ns/1ps
module tb_adcv_conv_sequencer;

    localparam int B            = 8;
    localparam int PIPE_LAT     = 6;
    localparam int AVG_LOG2_MAX = 4;
    localparam int PER_W        = 16;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic             stop = 1'b0;
    logic             res_ready = 1'b0;
    logic [PER_W-1:0] cfg_period = 16'd0;
    logic [2:0]       cfg_avg_log2 = 3'd0;
    logic [15:0]      cfg_count = 16'd0;
    logic             sample_valid;
    logic             res_valid;
    logic             busy;
    logic             overrun;
    logic             done;
    logic [B-1:0]     dec_bin;
    logic [B-1:0]     res_data;

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;
    int n_strobe, first_sv, last_sv, first_rv, n_hs, n_done, done_cyc, t0, stop_cyc;

    logic [B-1:0] code_q[$];
    logic [B-1:0] exp_q[$];

    adcv_conv_sequencer #(
        .B(B), .PIPE_LAT(PIPE_LAT), .AVG_LOG2_MAX(AVG_LOG2_MAX), .PER_W(PER_W)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .stop(stop),
        .cfg_period(cfg_period), .cfg_avg_log2(cfg_avg_log2), .cfg_count(cfg_count),
        .sample_valid(sample_valid), .dec_bin(dec_bin),
        .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
        .busy(busy), .overrun(overrun), .done(done)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Decoder model: returns the next queued code PIPE_LAT cycles after each strobe, 0 otherwise.
    logic [B-1:0]        pipe_d [PIPE_LAT];
    logic [PIPE_LAT-1:0] pipe_v;
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            pipe_v <= '0;
            for (int i = 0; i < PIPE_LAT; i++) pipe_d[i] <= 8'd0;
        end else begin
            logic [B-1:0] c;
            c = 8'd0;
            if (sample_valid && code_q.size() > 0) c = code_q.pop_front();
            pipe_v <= {pipe_v[PIPE_LAT-2:0], sample_valid};
            for (int i = PIPE_LAT - 1; i > 0; i--) pipe_d[i] <= pipe_d[i-1];
            pipe_d[0] <= c;
        end
    end
    assign dec_bin = pipe_v[PIPE_LAT-1] ? pipe_d[PIPE_LAT-1] : 8'd0;

    // Scoreboard monitor: every accepted result is compared with the oldest expectation.
    always @(negedge clock) begin
        #2;
        if (!reset && res_valid && res_ready) begin
            n_total++;
            if (exp_q.size() == 0) begin
                $display("FAIL result_unexpected: got %0d, expected no result", res_data);
            end else begin
                logic [B-1:0] e;
                e = exp_q.pop_front();
                if (res_data == e) n_pass++;
                else $display("FAIL result_data: got %0d, expected %0d", res_data, e);
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(negedge clock);
        if (sample_valid) begin
            n_strobe++;
            if (first_sv < 0) first_sv = cyc;
            last_sv = cyc;
        end
        if (res_valid && first_rv < 0) first_rv = cyc;
        if (res_valid && res_ready) n_hs++;
        if (done) begin
            n_done++;
            done_cyc = cyc;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic start_run(input logic [15:0] per, input logic [2:0] k, input logic [15:0] cnt);
        n_strobe = 0; first_sv = -1; last_sv = -1; first_rv = -1;
        n_hs = 0; n_done = 0; done_cyc = -1;
        cfg_period = per; cfg_avg_log2 = k; cfg_count = cnt;
        start = 1'b1;
        t0 = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        for (int i = 0; i < limit && n_done == 0; i++) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit, expected completion");
        $fatal(1);
    end

    initial begin
        idle(3);
        check("rst_sample_valid", int'(sample_valid), 0);
        check("rst_busy", int'(busy), 0);
        reset = 1'b0;
        idle(2);
        check("idle_res_valid", int'(res_valid), 0);
        check("idle_done", int'(done), 0);

        // period 1, k=0, count 4: one result per strobe
        res_ready = 1'b1;
        code_q = '{8'd37, 8'd38, 8'd39, 8'd40};
        exp_q.push_back(8'd37); exp_q.push_back(8'd38);
        exp_q.push_back(8'd39); exp_q.push_back(8'd40);
        start_run(16'd1, 3'd0, 16'd4);
        check("t1_busy_running", int'(busy), 1);
        wait_done(40); idle(4);
        check("t1_first_strobe", first_sv - t0, 1);
        check("t1_strobes", n_strobe, 4);
        check("t1_first_res_valid", first_rv - t0, PIPE_LAT + 2);
        check("t1_handshakes", n_hs, 4);
        check("t1_done_once", n_done, 1);
        check("t1_busy_after", int'(busy), 0);
        check("t1_sb_empty", exp_q.size(), 0);

        // downstream stalled: first result held, later ones dropped
        res_ready = 1'b0;
        code_q = '{8'd5, 8'd6, 8'd7};
        exp_q.push_back(8'd5);
        start_run(16'd1, 3'd0, 16'd3);
        wait_done(40); idle(3);
        check("t4_done_once", n_done, 1);
        check("t4_res_data_held", int'(res_data), 5);
        check("t4_overrun", int'(overrun), 1);
        check("t4_res_valid_idle", int'(res_valid), 1);
        check("t4_busy_after", int'(busy), 0);
        res_ready = 1'b1;
        idle(2);
        check("t4_res_valid_drop", int'(res_valid), 0);
        check("t4_sb_empty", exp_q.size(), 0);

        // period 3, k=2, count 1: (10+11+12+13)>>2 = 11
        code_q = '{8'd10, 8'd11, 8'd12, 8'd13};
        exp_q.push_back(8'd11);
        start_run(16'd3, 3'd2, 16'd1);
        wait_done(60); idle(4);
        check("t2_strobes", n_strobe, 4);
        check("t2_first_strobe", first_sv - t0, 1);
        check("t2_spacing", last_sv - first_sv, 9);
        check("t2_overrun_cleared", int'(overrun), 0);
        check("t2_done_once", n_done, 1);
        check("t2_sb_empty", exp_q.size(), 0);

        // k=4 with full-scale codes: no accumulator overflow
        for (int i = 0; i < 16; i++) code_q.push_back(8'd255);
        exp_q.push_back(8'd255);
        start_run(16'd1, 3'd4, 16'd1);
        wait_done(60); idle(4);
        check("t3_strobes", n_strobe, 16);
        check("t3_sb_empty", exp_q.size(), 0);

        // k=7 clipped to 4: codes 0..15 sum 120, >>4 = 7
        for (int i = 0; i < 16; i++) code_q.push_back(8'(i));
        exp_q.push_back(8'd7);
        start_run(16'd1, 3'd7, 16'd1);
        wait_done(60); idle(4);
        check("t3b_strobes", n_strobe, 16);
        check("t3b_sb_empty", exp_q.size(), 0);

        // continuous, period 0, k=2, stop after 6 strobes: only (1+2+3+4)>>2 = 2 emitted
        code_q = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd50, 8'd60};
        exp_q.push_back(8'd2);
        start_run(16'd0, 3'd2, 16'd0);
        for (int i = 0; i < 40 && n_strobe < 6; i++) tick();
        stop = 1'b1;
        stop_cyc = cyc;
        tick();
        stop = 1'b0;
        wait_done(40); idle(4);
        check("t5_strobes", n_strobe, 6);
        check("t5_every_cycle", last_sv - first_sv, 5);
        check("t5_done_latency", done_cyc - stop_cyc, PIPE_LAT + 1);
        check("t5_results", n_hs, 1);
        check("t5_done_once", n_done, 1);
        check("t5_sb_empty", exp_q.size(), 0);

        // reset asserted mid-run with samples in flight
        res_ready = 1'b0;
        for (int i = 0; i < 8; i++) code_q.push_back(8'(90 + i));
        start_run(16'd1, 3'd0, 16'd8);
        idle(7);
        reset = 1'b1;
        #1;
        check("t6_rst_sample_valid", int'(sample_valid), 0);
        check("t6_rst_res_valid", int'(res_valid), 0);
        check("t6_rst_res_data", int'(res_data), 0);
        check("t6_rst_busy", int'(busy), 0);
        check("t6_rst_overrun", int'(overrun), 0);
        check("t6_rst_done", int'(done), 0);
        code_q.delete();
        idle(2);
        reset = 1'b0;
        res_ready = 1'b1;
        n_strobe = 0; n_hs = 0;
        idle(12);
        check("t6_no_stale_valid", int'(res_valid), 0);
        check("t6_no_stale_hs", n_hs, 0);
        check("t6_no_strobes", n_strobe, 0);
        code_q = '{8'd7, 8'd8};
        exp_q.push_back(8'd7); exp_q.push_back(8'd8);
        start_run(16'd1, 3'd0, 16'd2);
        wait_done(40); idle(4);
        check("t6_rerun_results", n_hs, 2);
        check("t6_rerun_done", n_done, 1);
        check("t6_sb_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
